// File: rtl/i2c_slave.sv
// I2C target: filtered SCL/SDA, 7-bit address match, byte write/read.
// Define I2C_SLAVE_STRETCH_EN to add rd_valid_in and SCL stretching on reads.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h48,
  parameter int         FILTER_LEN = 3
) (
  input  logic       clk_in,
  input  logic       n_rst,
  inout  wire        SCL,
  inout  wire        SDA,
  output logic [7:0] wr_data_out,
  output logic       wr_valid_out,
  output logic       rd_req_out,
  input  logic [7:0] rd_data_in,
`ifdef I2C_SLAVE_STRETCH_EN
  input  logic       rd_valid_in,
`endif
  output logic       busy_out
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ADDR      = 3'd1;
  localparam logic [2:0] ADDR_ACK  = 3'd2;
  localparam logic [2:0] WRITE     = 3'd3;
  localparam logic [2:0] WRITE_ACK = 3'd4;
  localparam logic [2:0] READ      = 3'd5;
  localparam logic [2:0] READ_ACK  = 3'd6;
  localparam logic [2:0] WAIT_STOP = 3'd7;

  // bit 0 = SCL, bit 1 = SDA
  logic [1:0]    r_sync1;
  logic [1:0]    r_sync2;
  logic [1:0]    r_filt;
  logic [1:0]    r_filt_q;
  logic [CW-1:0] r_cnt [2];

  logic [2:0] r_state;
  logic [3:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic       r_rw;
  logic       r_sda_oe;
  logic       r_busy;
  logic [7:0] r_wr_data;
  logic       r_wr_valid;
`ifdef I2C_SLAVE_STRETCH_EN
  logic       r_scl_oe;
  logic       r_wait;
  logic       r_rel;
`endif

  logic w_sda;
  logic w_scl_rise;
  logic w_scl_fall;
  logic w_start;
  logic w_stop;
  logic w_load;

  always_ff @(posedge clk_in or negedge n_rst) begin
    if (!n_rst) begin
      r_sync1  <= 2'b11;
      r_sync2  <= 2'b11;
      r_filt   <= 2'b11;
      r_filt_q <= 2'b11;
      r_cnt    <= '{default: '0};
    end else begin
      r_sync1  <= {SDA, SCL};
      r_sync2  <= r_sync1;
      r_filt_q <= r_filt;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_filt[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CW'(FILTER_LEN - 1)) begin
          r_filt[i] <= r_sync2[i];
          r_cnt[i]  <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_sda      = r_filt[1];
  assign w_scl_rise = r_filt[0] & ~r_filt_q[0];
  assign w_scl_fall = ~r_filt[0] & r_filt_q[0];
  assign w_start    = r_filt[0] & r_filt_q[0] & r_filt_q[1] & ~r_filt[1];
  assign w_stop     = r_filt[0] & r_filt_q[0] & ~r_filt_q[1] & r_filt[1];

  // READ_ACK survives to the fall only when the controller ACKed
  assign w_load = w_scl_fall &
                  (((r_state == ADDR_ACK) & r_rw) | (r_state == READ_ACK));

  always_ff @(posedge clk_in or negedge n_rst) begin
    if (!n_rst) begin
      r_state    <= IDLE;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_rw       <= 1'b0;
      r_sda_oe   <= 1'b0;
      r_busy     <= 1'b0;
      r_wr_data  <= '0;
      r_wr_valid <= 1'b0;
`ifdef I2C_SLAVE_STRETCH_EN
      r_scl_oe   <= 1'b0;
      r_wait     <= 1'b0;
      r_rel      <= 1'b0;
`endif
    end else begin
      r_wr_valid <= 1'b0;
      if (w_start || w_stop) begin
        r_state   <= w_start ? ADDR : IDLE;
        r_bit_cnt <= '0;
        r_sda_oe  <= 1'b0;
        r_busy    <= w_start;
`ifdef I2C_SLAVE_STRETCH_EN
        r_scl_oe  <= 1'b0;
        r_wait    <= 1'b0;
        r_rel     <= 1'b0;
`endif
      end else begin
`ifdef I2C_SLAVE_STRETCH_EN
        if (r_rel) begin
          r_scl_oe <= 1'b0;
          r_rel    <= 1'b0;
        end
`endif
        unique case (r_state)
          ADDR, WRITE: begin
            if (w_scl_rise) begin
              r_shift   <= {r_shift[6:0], w_sda};
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
              r_bit_cnt <= '0;
              if (r_state == WRITE) begin
                r_wr_data  <= r_shift;
                r_wr_valid <= 1'b1;
                r_sda_oe   <= 1'b1;
                r_state    <= WRITE_ACK;
              end else if (r_shift[7:1] == SLAVE_ADDR) begin
                r_rw     <= r_shift[0];
                r_sda_oe <= 1'b1;
                r_state  <= ADDR_ACK;
              end else begin
                r_sda_oe <= 1'b0;
                r_state  <= WAIT_STOP;
              end
            end
          end
          ADDR_ACK: begin
            if (w_scl_fall) begin
              r_sda_oe <= 1'b0;
              if (!r_rw) r_state <= WRITE;
            end
          end
          WRITE_ACK: begin
            if (w_scl_fall) begin
              r_sda_oe <= 1'b0;
              r_state  <= WRITE;
            end
          end
          READ: begin
`ifdef I2C_SLAVE_STRETCH_EN
            if (r_wait) begin
              if (rd_valid_in) begin
                r_shift  <= rd_data_in;
                r_sda_oe <= ~rd_data_in[7];
                r_wait   <= 1'b0;
                r_rel    <= 1'b1;
              end
            end else
`endif
            if (w_scl_rise) begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end else if (w_scl_fall) begin
              if (r_bit_cnt == 4'd8) begin
                r_sda_oe <= 1'b0;
                r_state  <= READ_ACK;
              end else begin
                r_shift  <= {r_shift[6:0], 1'b0};
                r_sda_oe <= ~r_shift[6];
              end
            end
          end
          READ_ACK: begin
            if (w_scl_rise && w_sda) r_state <= WAIT_STOP;
          end
          default: begin
          end
        endcase
        if (w_load) begin
          r_state   <= READ;
          r_bit_cnt <= '0;
`ifdef I2C_SLAVE_STRETCH_EN
          r_sda_oe  <= 1'b0;
          r_wait    <= 1'b1;
          r_scl_oe  <= 1'b1;
`else
          r_shift   <= rd_data_in;
          r_sda_oe  <= ~rd_data_in[7];
`endif
        end
      end
    end
  end

  assign SDA = r_sda_oe ? 1'b0 : 1'bz;
`ifdef I2C_SLAVE_STRETCH_EN
  assign SCL = r_scl_oe ? 1'b0 : 1'bz;
`else
  assign SCL = 1'bz;
`endif

  assign wr_data_out  = r_wr_data;
  assign wr_valid_out = r_wr_valid;
  assign rd_req_out   = w_load;
  assign busy_out     = r_busy;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bit-banged controller with write/read scoreboards.
// Define I2C_SLAVE_STRETCH_EN to also exercise read clock stretching.
module tb_i2c_slave;

  localparam int Q = 20;

  logic       clk_in = 1'b0;
  logic       n_rst = 1'b0;
  wire        SCL;
  wire        SDA;
  logic [7:0] wr_data_out;
  logic       wr_valid_out;
  logic       rd_req_out;
  logic [7:0] rd_data_in = 8'h00;
  logic       busy_out;
`ifdef I2C_SLAVE_STRETCH_EN
  logic       rd_valid_in = 1'b0;
  int         lowrun = 0;
  logic       track = 1'b0;
`endif

  logic r_scl_low = 1'b0;
  logic r_sda_low = 1'b0;

  int n_tests = 0;
  int n_fail = 0;
  int n_wr = 0;
  int n_rdreq = 0;

  logic [7:0] q_wr[$];
  logic [7:0] q_rd_src[$];
  logic [8:0] q_rd_exp[$];

  assign SCL = r_scl_low ? 1'b0 : 1'bz;
  assign SDA = r_sda_low ? 1'b0 : 1'bz;
  pullup (SCL);
  pullup (SDA);

  always #5 clk_in = ~clk_in;

  i2c_slave #(.SLAVE_ADDR(7'h48), .FILTER_LEN(3)) dut (
    .clk_in      (clk_in),
    .n_rst       (n_rst),
    .SCL         (SCL),
    .SDA         (SDA),
    .wr_data_out (wr_data_out),
    .wr_valid_out(wr_valid_out),
    .rd_req_out  (rd_req_out),
    .rd_data_in  (rd_data_in),
`ifdef I2C_SLAVE_STRETCH_EN
    .rd_valid_in (rd_valid_in),
`endif
    .busy_out    (busy_out)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk_in) begin
    if (wr_valid_out) begin
      logic [31:0] e;
      n_wr++;
      e = (q_wr.size() != 0) ? 32'(q_wr.pop_front()) : 32'h100;
      chk("wr_data", 32'(wr_data_out), e);
    end
  end

  always @(negedge clk_in) begin
    if (rd_req_out) begin
      logic [8:0] nxt;
      n_rdreq++;
      nxt = (q_rd_src.size() != 0) ? {1'b0, q_rd_src.pop_front()} : 9'h100;
`ifdef I2C_SLAVE_STRETCH_EN
      repeat (50) @(negedge clk_in);
      rd_data_in  = nxt[7:0];
      rd_valid_in = 1'b1;
      q_rd_exp.push_back(nxt);
      @(negedge clk_in);
      rd_valid_in = 1'b0;
`else
      rd_data_in = nxt[7:0];
      q_rd_exp.push_back(nxt);
`endif
    end
  end

`ifdef I2C_SLAVE_STRETCH_EN
  always @(negedge clk_in) begin
    if (rd_req_out) begin
      lowrun <= 0;
      track  <= 1'b1;
    end else if (track) begin
      if (SCL == 1'b0) lowrun <= lowrun + 1;
      else track <= 1'b0;
    end
  end
`endif

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic wq();
    repeat (Q) @(negedge clk_in);
  endtask

  task automatic scl_rel();
    int n;
    n = 0;
    r_scl_low = 1'b0;
    while (SCL !== 1'b1 && n < 4000) begin
      @(negedge clk_in);
      n++;
    end
    if (n >= 4000) chk("scl_stuck", 32'(SCL), 1);
  endtask

  task automatic wbit(input logic b);
    r_sda_low = ~b;
    wq(); scl_rel(); wq(); wq();
    r_scl_low = 1'b1;
    wq();
  endtask

  task automatic rbit(output logic b);
    r_sda_low = 1'b0;
    wq(); scl_rel(); wq();
    b = SDA;
    wq();
    r_scl_low = 1'b1;
    wq();
  endtask

  task automatic i2c_start();
    r_sda_low = 1'b0;
    wq(); scl_rel(); wq();
    r_sda_low = 1'b1;
    wq();
    r_scl_low = 1'b1;
    wq();
  endtask

  task automatic i2c_stop();
    r_sda_low = 1'b1;
    wq(); scl_rel(); wq();
    r_sda_low = 1'b0;
    wq();
  endtask

  task automatic send_byte(input string tag, input logic [7:0] d,
                           input logic exp_sda);
    logic a;
    for (int i = 7; i >= 0; i--) wbit(d[i]);
    rbit(a);
    chk(tag, 32'(a), 32'(exp_sda));
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic nack);
    logic b;
    d = '0;
    for (int i = 7; i >= 0; i--) begin
      rbit(b);
      d = {d[6:0], b};
    end
    wbit(nack);
  endtask

  task automatic check_rd(input string tag, input logic [7:0] d);
    logic [31:0] e;
    e = (q_rd_exp.size() != 0) ? 32'(q_rd_exp.pop_front()) : 32'h100;
    chk(tag, 32'(d), e);
  endtask

  initial begin
    logic [7:0] d;
    int w0;
    int r0;
    repeat (5) @(negedge clk_in);
    chk("rst_busy", 32'(busy_out), 0);
    chk("rst_wrv", 32'(wr_valid_out), 0);
    chk("rst_rdreq", 32'(rd_req_out), 0);
    chk("rst_wrd", 32'(wr_data_out), 0);
    chk("rst_sda", 32'(SDA), 1);
    chk("rst_scl", 32'(SCL), 1);
    n_rst = 1'b1;
    wq();

    w0 = n_wr;
    i2c_start();
    chk("t1_busy_start", 32'(busy_out), 1);
    send_byte("t1_addr_ack", 8'h90, 1'b0);
    q_wr.push_back(8'h01);
    send_byte("t1_d0_ack", 8'h01, 1'b0);
    q_wr.push_back(8'h84);
    send_byte("t1_d1_ack", 8'h84, 1'b0);
    chk("t1_busy_mid", 32'(busy_out), 1);
    i2c_stop();
    wq();
    chk("t1_busy_stop", 32'(busy_out), 0);
    chk("t1_nwr", 32'(n_wr - w0), 2);

    w0 = n_wr;
    i2c_start();
    send_byte("t2_addr_nack", 8'h92, 1'b1);
    send_byte("t2_data_nack", 8'h33, 1'b1);
    i2c_stop();
    wq();
    chk("t2_nwr", 32'(n_wr - w0), 0);

    r0 = n_rdreq;
    q_rd_src.push_back(8'hA5);
    i2c_start();
    send_byte("t3_addr_ack", 8'h91, 1'b0);
    recv_byte(d, 1'b1);
    check_rd("t3_rd_a5", d);
    chk("t3_nreq", 32'(n_rdreq - r0), 1);
    recv_byte(d, 1'b1);
    chk("t3_wait_stop", 32'(d), 'hFF);
    i2c_stop();
    wq();
    chk("t3_busy_stop", 32'(busy_out), 0);

    r0 = n_rdreq;
    w0 = n_wr;
    i2c_start();
    send_byte("t4_waddr_ack", 8'h90, 1'b0);
    q_wr.push_back(8'h01);
    send_byte("t4_wd_ack", 8'h01, 1'b0);
    q_rd_src.push_back(8'h12);
    q_rd_src.push_back(8'h34);
    i2c_start();
    send_byte("t4_raddr_ack", 8'h91, 1'b0);
    recv_byte(d, 1'b0);
    check_rd("t4_rd0", d);
    recv_byte(d, 1'b1);
    check_rd("t4_rd1", d);
    i2c_stop();
    wq();
    chk("t4_nreq", 32'(n_rdreq - r0), 2);
    chk("t4_nwr", 32'(n_wr - w0), 1);

    i2c_start();
    for (int i = 7; i >= 0; i--) wbit(1'(8'h90 >> i));
    r_sda_low = 1'b0;
    wq();
    chk("t5_ack_drv", 32'(SDA), 0);
    n_rst = 1'b0;
    #1;
    chk("t5_rst_rel", 32'(SDA), 1);
    chk("t5_rst_busy", 32'(busy_out), 0);
    repeat (5) @(negedge clk_in);
    n_rst = 1'b1;
    wq();
    i2c_stop();
    w0 = n_wr;
    i2c_start();
    send_byte("t5_addr_ack", 8'h90, 1'b0);
    q_wr.push_back(8'h5A);
    send_byte("t5_d_ack", 8'h5A, 1'b0);
    i2c_stop();
    wq();
    chk("t5_nwr", 32'(n_wr - w0), 1);

`ifdef I2C_SLAVE_STRETCH_EN
    r0 = n_rdreq;
    q_rd_src.push_back(8'hC3);
    i2c_start();
    send_byte("t6_addr_ack", 8'h91, 1'b0);
    recv_byte(d, 1'b1);
    check_rd("t6_rd_c3", d);
    chk("t6_stretch50", 32'(lowrun >= 50), 1);
    chk("t6_nreq", 32'(n_rdreq - r0), 1);
    i2c_stop();
    wq();
`endif

    chk("q_wr_left", 32'(q_wr.size()), 0);
    chk("q_rd_left", 32'(q_rd_exp.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_slave.md
I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h48, the 7-bit address this target answers to.
REQ-002 SHALL have parameter FILTER_LEN, default 3, the number of consecutive equal samples required to accept a new SCL/SDA level.
REQ-003 SHALL have port clk_in, input, 1 bit: system clock; the block's only clock.
REQ-004 SHALL have port n_rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port SCL, inout, 1 bit: I2C clock, open-drain (drives 0 or Z).
REQ-006 SHALL have port SDA, inout, 1 bit: I2C data, open-drain (drives 0 or Z).
REQ-007 SHALL have port wr_data_out, output, 8 bits: last byte received from the controller.
REQ-008 SHALL have port wr_valid_out, output, 1 bit: one-cycle pulse marking a new wr_data_out.
REQ-009 SHALL have port rd_req_out, output, 1 bit: one-cycle pulse requesting the next byte to transmit.
REQ-010 SHALL have port rd_data_in, input, 8 bits: byte to transmit to the controller.
REQ-011 SHALL have port busy_out, output, 1 bit: high from detected START until detected STOP.

Function
REQ-012 SHALL pass SCL and SDA through a 2-FF synchronizer (preset 1) and then a FILTER_LEN-sample glitch filter; all later logic SHALL use only the filtered levels.
REQ-013 SHALL detect START as filtered SDA 1->0 while SCL=1, STOP as SDA 0->1 while SCL=1, and SCL rise/fall as single-cycle edge strobes.
REQ-014 SHALL implement states IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, WAIT_STOP.
REQ-015 SHALL enter ADDR on START from any state (repeated START included) and clear the bit counter.
REQ-016 SHALL enter IDLE on STOP from any state, release SDA, and drop busy_out.
REQ-017 SHALL shift SDA in MSB-first on each SCL rise in ADDR/WRITE and change its own SDA only on the cycle after an SCL fall.
REQ-018 After the 8th address bit, on a match with SLAVE_ADDR, SHALL drive SDA=0 from that SCL fall until the next SCL fall (ADDR_ACK); on a mismatch it SHALL release SDA and go to WAIT_STOP.
REQ-019 With R/W=0, SHALL go ADDR_ACK->WRITE; after each 8th bit SHALL latch wr_data_out, pulse wr_valid_out for 1 cycle on the SCL fall, and ACK (WRITE_ACK), then return to WRITE.
REQ-020 With R/W=1, SHALL pulse rd_req_out on the SCL fall ending the ACK bit, sample rd_data_in in that same cycle, and drive bit 7 in the following cycle.
REQ-021 In READ_ACK SHALL release SDA and sample the controller's bit on the SCL rise; ACK(0) -> next byte as in REQ-020; NACK(1) -> WAIT_STOP with SDA released.
REQ-022 In WAIT_STOP and IDLE SHALL never drive SDA or SCL.
REQ-023 SHALL NOT run a byte counter limit; any number of bytes per transaction SHALL be accepted.

Reset
REQ-024 On n_rst=0 SHALL immediately release SDA and SCL, go to IDLE, and clear wr_data_out=0, wr_valid_out=0, rd_req_out=0, busy_out=0, and the synchronizer/filter to 1; this applies mid-transfer as well.
REQ-025 After reset release, SHALL ignore the bus until the first START.

Configuration
REQ-026 Macro I2C_SLAVE_STRETCH_EN, when defined, SHALL add input rd_valid_in (1 bit).
REQ-027 With the macro defined, after rd_req_out the block SHALL hold SCL=0 until rd_valid_in=1, capture rd_data_in in that cycle, drive bit 7, and release SCL one cycle later.
REQ-028 Without the macro, rd_valid_in SHALL NOT exist, SCL SHALL never be driven, and REQ-020 timing SHALL apply.

Verification
REQ-029 Write to 0x48, data 0x01, 0x84, STOP -> three ACKs; wr_valid_out pulses twice with 0x01 then 0x84; busy_out falls after STOP.
REQ-030 Address 0x49 with write -> SDA stays released on the 9th clock (NACK); no wr_valid_out pulses until the next START.
REQ-031 Read from 0x48 with rd_data_in=0xA5 and controller NACK -> SDA carries 1010_0101; one rd_req_out pulse; WAIT_STOP reached.
REQ-032 Write 0x48 + 0x01, then repeated START, then read 0x48 (two bytes 0x12, 0x34, ACK then NACK) -> two rd_req_out pulses and correct serial bytes.
REQ-033 n_rst asserted while the target drives an ACK low -> SDA released in the same cycle; a subsequent transaction succeeds.
REQ-034 With I2C_SLAVE_STRETCH_EN, rd_valid_in delayed 50 cycles after rd_req_out -> SCL held low for >=50 cycles; byte transmitted correctly.
